skid_buffer: RTL and testbench
==============================

// Module: skid_buffer
//
// PURPOSE
//  Two-entry valid/ready pipeline slice ahead of dffen-based datapath stages.
//  Breaks the combinational ready path: in_rdy is a pure flop output.
//  Sustains full throughput (1 beat/cycle) under continuous flow.
//  Storage is built from dffen instances, so payload flops carry no reset.
//
// PARAMETERS
//  W     32   payload width in bits (>= 1)
//
// PORTS
//  clk         in   1      clock; all flops rise on posedge
//  arst        in   1      asynchronous reset, active-high
//  in_vld      in   1      upstream beat valid
//  in_w        in   W      upstream payload
//  in_rdy      out  1      buffer accepts a beat this cycle; registered
//  out_vld     out  1      downstream beat valid; registered
//  out_w       out  W      downstream payload; registered, straight from the out register
//  out_rdy     in   1      downstream accepts a beat this cycle
//  stall_cnt   out  32     present only with SKID_BUFFER_STATS_EN
//
// BEHAVIOUR
//  - Transfers: in fires = in_vld & in_rdy; out fires = out_vld & out_rdy.
//  - Reset (arst=1, async): state=EMPTY, out_vld=0, in_rdy=1, stall_cnt=0.
//    out_w and skid payload are X until first write; bench must not sample them.
//  - States (skid_buffer_pkg::state_t):
//    - EMPTY: out_vld=0, in_rdy=1.
//    - BUSY: out register holds 1 beat; out_vld=1, in_rdy=1.
//    - FULL: out register plus skid register hold 2 beats; out_vld=1, in_rdy=0.
//  - Transitions:
//    - EMPTY + in fire -> BUSY. Write out register. Latency in->out = 1 cycle.
//    - BUSY + in fire + out fire -> BUSY. Out register <= in_w (pass-through).
//    - BUSY + in fire, no out fire -> FULL. Skid register <= in_w.
//    - BUSY + out fire, no in fire -> EMPTY.
//    - FULL + out fire -> BUSY. Out register <= skid register. in_fire is impossible (in_rdy=0).
//    - All other combinations hold state.
//  - Ordering: beats leave strictly in acceptance order; no drop, no duplicate.
//  - out_vld/out_w are stable while out_vld & ~out_rdy (AXI-style hold).
//  - in_vld with in_rdy=0 has no effect; upstream must hold its beat.
//  - in_rdy deasserts exactly one cycle after the beat that filled the skid register.
//  - arst mid-transfer: both entries are discarded immediately. Outputs take reset
//    values asynchronously; operation restarts on the first posedge after release.
//  - Enables are decoded combinationally: out_en, skid_en, out_sel (skid vs. in_w).
//    They drive the dffen .en/.d pins; no other payload muxing is permitted.
//
// CONFIGURATION
//  SKID_BUFFER_STATS_EN defined:
//    - stall_cnt increments on every cycle with out_vld & ~out_rdy.
//    - Saturates at 32'hFFFF_FFFF; reset to 0 by arst.
//  SKID_BUFFER_STATS_EN undefined: port and counter are absent; zero area.
//
// STRUCTURE
//  - skid_buffer_pkg: state_t enum {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
//    Also holds the STALL_CNT_W=32 constant.
//  - State, out_vld and in_rdy: one always_ff with async arst.
//  - Payload: two dffen #(W) instances (u_out_reg, u_skid_reg).
//  - No new sub-module is required; dffen is the only child.
//
// TESTING
//  1 Reset: arst=1 mid-run -> same cycle out_vld=0, in_rdy=1; after release, state=EMPTY.
//  2 Streaming: out_rdy=1, in_vld=1 for 8 cycles, in_w=0..7
//    -> out_w=0..7 on cycles 1..8; in_rdy never drops.
//  3 Backpressure: out_rdy=0, send 0xA then 0xB
//    -> in_rdy=0 from the cycle after 0xB; out_w holds 0xA.
//    Then raise out_rdy: 0xA then 0xB emerge; in_rdy=1 the cycle after 0xA leaves.
//  4 Simultaneous: BUSY holding 0x1, in fire 0x2 plus out fire same cycle
//    -> next cycle out_w=0x2, state BUSY.
//  5 Random: random in_vld/out_rdy over 10k cycles vs. scoreboard queue
//    -> zero mismatch, zero loss; out_w stable while stalled.
//  6 Stats (SKID_BUFFER_STATS_EN): hold out_rdy=0 with out_vld=1 for 5 cycles -> stall_cnt=5.

Source files
------------

// File: rtl/skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : skid_buffer_pkg
// Purpose  : Shared types and constants for the skid_buffer pipeline slice.
//            state_t encodes buffer occupancy (EMPTY / BUSY / FULL).
//            STALL_CNT_W sizes the optional stall counter, which is present
//            when SKID_BUFFER_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package skid_buffer_pkg;

    localparam int STALL_CNT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,   // no beat held
        BUSY  = 2'b01,   // out register holds one beat
        FULL  = 2'b10    // out register and skid register both hold a beat
    } state_t;

endpackage : skid_buffer_pkg
`default_nettype wire

// File: rtl/dffen.sv
`default_nettype none
// ============================================================================
// Module   : dffen
// Purpose  : W-bit clock-enabled register without reset (payload storage).
// Ports    : clk  in  1   clock, rising edge
//            en   in  1   load enable
//            d    in  W   data in
//            q    out W   registered data
// Revision : 1.0 - initial release
// ============================================================================
module dffen #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule : dffen
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : skid_buffer
// Purpose  : Two-entry valid/ready pipeline slice. in_rdy and out_vld are
//            flop outputs, so no combinational path runs from out_rdy to
//            in_rdy. Full throughput is sustained under continuous flow.
//            Payload lives in two reset-less dffen registers (out, skid).
// Ports    : clk        in   1    clock
//            arst       in   1    asynchronous reset, active-high
//            in_vld     in   1    upstream valid
//            in_w       in   W    upstream payload
//            in_rdy     out  1    buffer accepts a beat (registered)
//            out_vld    out  1    downstream valid (registered)
//            out_w      out  W    downstream payload (out register)
//            out_rdy    in   1    downstream accepts a beat
//            stall_cnt  out  32   saturating stall counter; present only
//                                 when SKID_BUFFER_STATS_EN is defined
// Config   : SKID_BUFFER_STATS_EN - enables the stall counter and its port.
// Revision : 1.0 - initial release
// ============================================================================
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   in_vld,
    input  logic [W-1:0]           in_w,
    output logic                   in_rdy,
    output logic                   out_vld,
    output logic [W-1:0]           out_w,
    input  logic                   out_rdy
`ifdef SKID_BUFFER_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    state_t         state_q;
    state_t         state_d;
    logic           out_vld_q;
    logic           in_rdy_q;

    logic           in_fire;
    logic           out_fire;
    logic           out_en;
    logic           skid_en;
    logic           out_sel;
    logic [W-1:0]   out_d;
    logic [W-1:0]   skid_q;

    assign in_fire  = in_vld & in_rdy_q;
    assign out_fire = out_vld_q & out_rdy;

    // Out register loads when it is (or is becoming) free and a beat is
    // available: a new input when EMPTY or passing through in BUSY, or the
    // skid entry when draining from FULL.
    assign out_en  = ((state_q == EMPTY) & in_fire)
                   | ((state_q == BUSY)  & in_fire & out_fire)
                   | ((state_q == FULL)  & out_fire);
    // Skid register only captures the beat that arrives while the out
    // register is occupied and stalled.
    assign skid_en = (state_q == BUSY) & in_fire & ~out_fire;
    // In FULL the oldest waiting beat is the skid entry, never in_w.
    assign out_sel = (state_q == FULL);
    assign out_d   = out_sel ? skid_q : in_w;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && !out_fire) begin
                    state_d = FULL;
                end else if (!in_fire && out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they never
    // depend combinationally on out_rdy.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= EMPTY;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_vld_q <= (state_d != EMPTY);
            in_rdy_q  <= (state_d != FULL);
        end
    end

    dffen #(.W(W)) u_out_reg (
        .clk (clk),
        .en  (out_en),
        .d   (out_d),
        .q   (out_w)
    );

    dffen #(.W(W)) u_skid_reg (
        .clk (clk),
        .en  (skid_en),
        .d   (in_w),
        .q   (skid_q)
    );

    assign out_vld = out_vld_q;
    assign in_rdy  = in_rdy_q;

`ifdef SKID_BUFFER_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q <= '0;
        end else if (out_vld_q && !out_rdy && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : skid_buffer
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid_buffer
// Purpose  : Self-checking bench for skid_buffer. A driver issues beats and
//            pushes every accepted beat into a reference queue; a monitor
//            pops and compares whenever the DUT emits a beat, and checks the
//            handshake flags against the queue occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skid_buffer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic          in_vld;
    logic [W-1:0]  in_w;
    logic          in_rdy;
    logic          out_vld;
    logic [W-1:0]  out_w;
    logic          out_rdy;
`ifdef SKID_BUFFER_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   stall_exp;
`endif

    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  exp_q[$];
    logic          mon_en  = 1'b0;
    logic          hold_prev = 1'b0;
    logic [W-1:0]  prev_w;

    skid_buffer #(.W(W)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_vld    (in_vld),
        .in_w      (in_w),
        .in_rdy    (in_rdy),
        .out_vld   (out_vld),
        .out_w     (out_w),
        .out_rdy   (out_rdy)
`ifdef SKID_BUFFER_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Called at posedge+2: drive inputs, record acceptance just before the
    // next edge, return at the following posedge+2.
    task automatic cycle(input logic v, input logic [W-1:0] w, input logic r, output logic acc);
        in_vld  = v;
        in_w    = w;
        out_rdy = r;
        #5;
        acc = in_vld && in_rdy;
        if (acc) exp_q.push_back(in_w);
        @(posedge clk);
        #2;
    endtask

    // Monitor: samples mid-cycle, before the edge at which transfers occur.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("occupancy_vld", {31'd0, out_vld}, {31'd0, exp_q.size() > 0});
            chk("occupancy_rdy", {31'd0, in_rdy},  {31'd0, exp_q.size() < 2});
            if (hold_prev) begin
                chk("hold_vld", {31'd0, out_vld}, 32'd1);
                chk("hold_data", out_w, prev_w);
            end
`ifdef SKID_BUFFER_STATS_EN
            chk("stall_cnt", stall_cnt, stall_exp);
            if (out_vld && !out_rdy && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 1;
`endif
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL underflow: got beat %0h want none", out_w);
                end else begin
                    chk("data_order", out_w, exp_q.pop_front());
                end
            end
            hold_prev = out_vld && !out_rdy;
            if (out_vld) prev_w = out_w;
        end
    end

    initial begin
        logic         acc;
        logic         cur_v;
        logic [W-1:0] cur_w;
        logic [W-1:0] seq;

        arst    = 1'b1;
        in_vld  = 1'b0;
        in_w    = '0;
        out_rdy = 1'b0;
        prev_w  = '0;
`ifdef SKID_BUFFER_STATS_EN
        stall_exp = '0;
`endif
        #1;
        chk("reset_out_vld", {31'd0, out_vld}, 32'd0);
        chk("reset_in_rdy",  {31'd0, in_rdy},  32'd1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        arst   = 1'b0;
        mon_en = 1'b1;

        // Streaming: one beat per cycle, one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, W'(i), 1'b1, acc);
            chk("stream_acc", {31'd0, acc}, 32'd1);
            chk("stream_out", out_w, W'(i));
        end
        cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, acc);

        // Backpressure: fill both entries, then drain in order.
        cycle(1'b1, 32'hA, 1'b0, acc);
        chk("bp_out_a", out_w, 32'hA);
        cycle(1'b1, 32'hB, 1'b0, acc);
        chk("bp_rdy_low", {31'd0, in_rdy}, 32'd0);
        chk("bp_hold_a", out_w, 32'hA);
        cycle(1'b1, 32'hC, 1'b0, acc);
        chk("bp_blocked", {31'd0, acc}, 32'd0);
        cycle(1'b0, '0, 1'b1, acc);
        chk("bp_out_b", out_w, 32'hB);
        chk("bp_rdy_back", {31'd0, in_rdy}, 32'd1);
        cycle(1'b0, '0, 1'b1, acc);
        chk("bp_empty", {31'd0, out_vld}, 32'd0);

        // Simultaneous in and out fire while BUSY.
        cycle(1'b1, 32'h1, 1'b0, acc);
        cycle(1'b1, 32'h2, 1'b1, acc);
        chk("sim_out", out_w, 32'h2);
        chk("sim_vld", {31'd0, out_vld}, 32'd1);
        chk("sim_rdy", {31'd0, in_rdy}, 32'd1);
        cycle(1'b0, '0, 1'b1, acc);

`ifdef SKID_BUFFER_STATS_EN
        begin
            logic [31:0] s0;
            s0 = stall_cnt;
            cycle(1'b1, 32'h55, 1'b0, acc);
            for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, acc);
            chk("stats_five", stall_cnt, s0 + 32'd5);
            cycle(1'b0, '0, 1'b1, acc);
        end
`endif

        // Reset mid-transfer with both entries occupied.
        cycle(1'b1, 32'h10, 1'b0, acc);
        cycle(1'b1, 32'h11, 1'b0, acc);
        mon_en = 1'b0;
        in_vld = 1'b0;
        arst   = 1'b1;
        #1;
        chk("midrst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("midrst_in_rdy",  {31'd0, in_rdy},  32'd1);
        exp_q.delete();
        hold_prev = 1'b0;
`ifdef SKID_BUFFER_STATS_EN
        stall_exp = '0;
        chk("midrst_stall", stall_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        @(posedge clk); #2;
        arst   = 1'b0;
        mon_en = 1'b1;
        cycle(1'b0, '0, 1'b1, acc);
        chk("post_rst_empty", {31'd0, out_vld}, 32'd0);

        // Random traffic; a beat is held until accepted.
        cur_v = 1'b0;
        cur_w = '0;
        seq   = 32'h100;
        for (int n = 0; n < 10000; n++) begin
            if (!cur_v || acc) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_w = {$urandom_range(0, 255)} << 24 | seq;
                seq   = seq + 1;
            end
            cycle(cur_v, cur_w, ($urandom_range(0, 2) != 0), acc);
            if (!cur_v) acc = 1'b0;
        end

        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, acc);
        chk("drain_empty", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_skid_buffer
`default_nettype wire
